bmem_line_adapter: RTL and testbench
====================================

# bmem_line_adapter

Bridges one 256-bit cacheline client (the last-level cache's downstream port) to the 64-bit banked memory interface driven by the CPU (`bmem_addr`/`read`/`write`/`wdata`/`ready`/`raddr`/`rdata`/`rvalid`). It serialises line writes into 4-beat write bursts, issues single-cycle read requests, and reassembles the 4 returning read beats into a line. It is the initiator for the banked memory model used by the top-level bench. One transaction is outstanding at a time.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `BEAT_WIDTH`, 64, bmem data beat width
- `BEATS`, 4, beats per line; line width = `BEAT_WIDTH*BEATS` (256)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `dfp_addr`  in  ADDR_WIDTH  line address; bits [4:0] ignored
- `dfp_read`  in  1  line read request, held until `dfp_resp`
- `dfp_write`  in  1  line write request, held until `dfp_resp`
- `dfp_wdata`  in  256  write line
- `dfp_rdata`  out  256  read line, valid with `dfp_resp`
- `dfp_resp`  out  1  one-cycle completion pulse
- `bmem_addr`  out  ADDR_WIDTH  request address, 32-byte aligned
- `bmem_read`  out  1  read request
- `bmem_write`  out  1  write beat valid
- `bmem_wdata`  out  BEAT_WIDTH  write beat
- `bmem_ready`  in  1  memory accepts request / first write beat
- `bmem_raddr`  in  ADDR_WIDTH  address tag of returning beat
- `bmem_rdata`  in  BEAT_WIDTH  returning beat
- `bmem_rvalid`  in  1  returning beat valid

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR, RESP.
- IDLE: if `dfp_read`, latch `{dfp_addr[31:5],5'b0}` and go to RD_REQ; else if `dfp_write`, latch address and `dfp_wdata`, and go to WR with beat=0. Read has priority when both are asserted (an illegal client input, but its behaviour is defined).
- RD_REQ: drive `bmem_read=1` and `bmem_addr`. If `bmem_ready`, go to RD_WAIT with beat=0; else hold.
- RD_WAIT: each accepted `bmem_rvalid` beat is written into line slot `beat`, with beat 0 going to bits [63:0]. The beat counter then increments. On the 4th beat, go to RESP.
- WR: drive `bmem_write=1`, `bmem_addr`, and `bmem_wdata` = latched line slice `beat`.
  - Beat 0 advances only if `bmem_ready=1`.
  - Beats 1–3 advance unconditionally on consecutive cycles; they are never stalled.
  - After beat 3, go to RESP.
- RESP: `dfp_resp=1` for exactly one cycle, then go to IDLE. `dfp_rdata` holds the assembled line until the next read completes.
- `bmem_rvalid` outside RD_WAIT is ignored. This covers stale beats after a reset.
- The beat counter is 2 bits and wraps naturally from 3 to 0.

## Timing
- All outputs are registered. Reset values: `bmem_read=0`, `bmem_write=0`, `bmem_addr=0`, `bmem_wdata=0`, `dfp_resp=0`, `dfp_rdata=0`. Reset also sets state to IDLE and beat to 0.
- Read: request sampled at edge N; `bmem_read` is high in cycle N+1. With `ready` high, that is its only high cycle. When the 4th beat is sampled at edge M, `dfp_resp` is high in cycle M+1.
- Write: request sampled at edge N; beats occupy cycles N+1..N+4 when `ready` is high. `dfp_resp` is high in cycle N+5. `bmem_write` is high for exactly 4 cycles, plus any beat-0 stall cycles.
- The client must drop its request in the cycle after `dfp_resp`. The earliest the adapter accepts a new request is the edge ending the cycle after RESP.
- Reset asserted mid-burst aborts immediately with outputs at their reset values. A partial write burst is not completed.

## Configuration
- Macro: `BMEM_RADDR_CHECK_EN`.
- Defined: in RD_WAIT, a beat is accepted only if `bmem_raddr` equals the latched aligned address. Mismatched beats are dropped and not counted. In simulation, each dropped beat triggers an `$error`.
- Undefined: every `bmem_rvalid` in RD_WAIT is accepted, and `bmem_raddr` is unused.

## Structure
- `bmem_pkg` holds:
  - the state enum;
  - `BMEM_BEATS`, `BMEM_BEAT_W`, `LINE_W`;
  - the typedef `line_t` (`logic [255:0]`).
- The design is a single module with no sub-module. Beat insertion and extraction are indexed part-selects.

## Test plan
- Read line 0x0000_1040: `dfp_read` with `ready=1`, memory returns 0x11..,0x22..,0x33..,0x44.. on 4 consecutive cycles. `dfp_resp` must assert one cycle after the last beat, with `dfp_rdata[63:0]`=0x11.. and `dfp_rdata[255:192]`=0x44..
- Write to 0x0000_2000 with line {D3,D2,D1,D0}: `bmem_write` must be high for cycles N+1..N+4 carrying D0..D3 with `bmem_addr`=0x2000, and `dfp_resp` must assert at N+5.
- Hold `ready=0` for 3 cycles on a read and on a write: `bmem_read` and write beat 0 must be held steady for those 3 cycles, and beats 1–3 must remain back-to-back.
- Read with gapped rvalid (beats 2 cycles apart), plus a spurious rvalid in IDLE: the line must be assembled correctly, and the IDLE beat must not affect the next read.
- Reset asserted during write beat 2: outputs must go to 0 immediately. A following read to 0x3000 must complete normally. With `BMEM_RADDR_CHECK_EN`, beats tagged 0x2000 must be dropped, and `dfp_resp` must occur only after 4 beats tagged 0x3000.
- `dfp_addr`=0x0000_105F: `bmem_addr` must be 0x0000_1040.

Source files
------------

// File: rtl/bmem_pkg.sv
// Shared types and sizing for the cacheline-to-banked-memory adapter.
package bmem_pkg;

  localparam int BMEM_BEATS  = 4;
  localparam int BMEM_BEAT_W = 64;
  localparam int LINE_W      = BMEM_BEATS * BMEM_BEAT_W;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    RESP
  } bmem_state_e;

endpackage

// File: rtl/bmem_line_adapter.sv
// Serialises 256-bit line transfers onto the 64-bit banked memory port, one transaction at a time.
// Optional macro BMEM_RADDR_CHECK_EN: only accept read beats whose address tag matches the request.
module bmem_line_adapter
  import bmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = BMEM_BEAT_W,
  parameter int BEATS      = BMEM_BEATS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       dfp_addr,
  input  logic                        dfp_read,
  input  logic                        dfp_write,
  input  logic [BEAT_WIDTH*BEATS-1:0] dfp_wdata,
  output logic [BEAT_WIDTH*BEATS-1:0] dfp_rdata,
  output logic                        dfp_resp,
  output logic [ADDR_WIDTH-1:0]       bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_WIDTH-1:0]       bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [ADDR_WIDTH-1:0]       bmem_raddr,
  input  logic [BEAT_WIDTH-1:0]       bmem_rdata,
  input  logic                        bmem_rvalid
);

  localparam int LINE_BITS  = BEAT_WIDTH * BEATS;
  localparam int OFS_W      = $clog2(LINE_BITS / 8);
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  bmem_state_e                 state_q, state_d;
  logic [BEAT_IDX_W-1:0]       beat_q, beat_d;
  logic [LINE_BITS-1:0]        line_q, line_d;
  logic [LINE_BITS-1:0]        rdata_q, rdata_d;
  logic                        resp_q, resp_d;
  logic [ADDR_WIDTH-1:0]       bmem_addr_q, bmem_addr_d;
  logic                        bmem_read_q, bmem_read_d;
  logic                        bmem_write_q, bmem_write_d;
  logic [BEAT_WIDTH-1:0]       bmem_wdata_q, bmem_wdata_d;

  logic [ADDR_WIDTH-1:0]       aligned_addr;
  logic                        beat_accept;
  logic                        unused_bits;

  assign aligned_addr = {dfp_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};

`ifdef BMEM_RADDR_CHECK_EN
  // bmem_addr_q keeps the aligned request address for the whole transaction.
  assign beat_accept = bmem_rvalid && (bmem_raddr == bmem_addr_q);
  assign unused_bits = ^dfp_addr[OFS_W-1:0];

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && state_q == RD_WAIT && bmem_rvalid && bmem_raddr != bmem_addr_q)
      $error("bmem_line_adapter: dropped beat tagged %h, expected %h", bmem_raddr, bmem_addr_q);
  end
`endif
`else
  assign beat_accept = bmem_rvalid;
  assign unused_bits = ^{bmem_raddr, dfp_addr[OFS_W-1:0]};
`endif

  always_comb begin
    logic [BEAT_IDX_W-1:0] beat_inc;
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    rdata_d      = rdata_q;
    resp_d       = 1'b0;
    bmem_addr_d  = bmem_addr_q;
    bmem_read_d  = bmem_read_q;
    bmem_write_d = bmem_write_q;
    bmem_wdata_d = bmem_wdata_q;
    beat_inc     = beat_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (dfp_read) begin
          state_d     = RD_REQ;
          bmem_read_d = 1'b1;
          bmem_addr_d = aligned_addr;
        end else if (dfp_write) begin
          state_d      = WR;
          beat_d       = '0;
          line_d       = dfp_wdata;
          bmem_write_d = 1'b1;
          bmem_addr_d  = aligned_addr;
          bmem_wdata_d = dfp_wdata[BEAT_WIDTH-1:0];
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_d     = RD_WAIT;
          beat_d      = '0;
          bmem_read_d = 1'b0;
        end
      end
      RD_WAIT: begin
        if (beat_accept) begin
          line_d[int'(beat_q)*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
          beat_d = beat_inc;
          if (beat_q == LAST_BEAT) begin
            // Publish the finished line only now so dfp_rdata holds the previous read until then.
            state_d = RESP;
            resp_d  = 1'b1;
            rdata_d = line_d;
          end
        end
      end
      WR: begin
        // Only the first beat waits for ready; the rest stream back-to-back.
        if (bmem_ready || beat_q != '0) begin
          beat_d       = beat_inc;
          bmem_wdata_d = line_q[int'(beat_inc)*BEAT_WIDTH +: BEAT_WIDTH];
          if (beat_q == LAST_BEAT) begin
            state_d      = RESP;
            bmem_write_d = 1'b0;
            resp_d       = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      rdata_q      <= '0;
      resp_q       <= 1'b0;
      bmem_addr_q  <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      beat_q       <= beat_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      bmem_addr_q  <= bmem_addr_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_wdata_q <= bmem_wdata_d;
    end
  end

  // NOTE: the line buffer is pure datapath, always overwritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign dfp_rdata  = rdata_q;
  assign dfp_resp   = resp_q;
  assign bmem_addr  = bmem_addr_q;
  assign bmem_read  = bmem_read_q;
  assign bmem_write = bmem_write_q;
  assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Self-checking bench for bmem_line_adapter: directed table, corner sequences, random traffic.
module tb_bmem_line_adapter;
  import bmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dfp_addr = '0;
  logic        dfp_read = 1'b0;
  logic        dfp_write = 1'b0;
  line_t       dfp_wdata = '0;
  line_t       dfp_rdata;
  logic        dfp_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready = 1'b0;
  logic [31:0] bmem_raddr = '0;
  logic [63:0] bmem_rdata = '0;
  logic        bmem_rvalid = 1'b0;

  bmem_line_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  line_t mem [logic [31:0]];
  line_t last_rd = '0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    line_t       line;
    int          stall;
    int          gap;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic line_t mem_line(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = rand_line();
    return mem[a];
  endfunction

  // Read transaction; called and returns at a negedge with the adapter idle.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_a, input int stall, input int gap);
    line_t ln;
    ln = mem_line(exp_a);
    dfp_addr = addr;
    dfp_read = 1'b1;
    bmem_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < stall; k++) begin
      check("rd_req_held", bmem_read, 1);
      check("rd_addr", bmem_addr, exp_a);
      @(negedge clk);
    end
    bmem_ready = 1'b1;
    check("rd_req", bmem_read, 1);
    check("rd_addr", bmem_addr, exp_a);
    @(negedge clk);
    bmem_ready = 1'($urandom_range(0, 1));
    check("rd_req_once", bmem_read, 0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
`ifdef BMEM_RADDR_CHECK_EN
        bmem_rvalid = 1'b1;
        bmem_raddr  = (exp_a != 32'h2000) ? 32'h2000 : 32'h2020;
        bmem_rdata  = {$urandom, $urandom};
`endif
        check("rd_no_early_resp", dfp_resp, 0);
        @(negedge clk);
        bmem_rvalid = 1'b0;
      end
      bmem_rvalid = 1'b1;
      bmem_raddr  = exp_a;
      bmem_rdata  = ln[b*64 +: 64];
      check("rd_no_early_resp", dfp_resp, 0);
      @(negedge clk);
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
    end
    check("rd_resp", dfp_resp, 1);
    check("rd_rdata", dfp_rdata, ln);
    dfp_read = 1'b0;
    last_rd = ln;
    @(negedge clk);
    check("rd_resp_pulse", dfp_resp, 0);
    check("rd_rdata_hold", dfp_rdata, last_rd);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_a, input line_t ln, input int stall);
    dfp_addr = addr;
    dfp_wdata = ln;
    dfp_write = 1'b1;
    bmem_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < stall; k++) begin
      check("wr_beat0_held", bmem_write, 1);
      check("wr_beat0_data", bmem_wdata, ln[63:0]);
      check("wr_addr", bmem_addr, exp_a);
      @(negedge clk);
    end
    bmem_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check("wr_valid", bmem_write, 1);
      check("wr_beat", bmem_wdata, ln[b*64 +: 64]);
      check("wr_addr", bmem_addr, exp_a);
      check("wr_no_early_resp", dfp_resp, 0);
      @(negedge clk);
      bmem_ready = 1'($urandom_range(0, 1));
    end
    check("wr_done", bmem_write, 0);
    check("wr_resp", dfp_resp, 1);
    check("wr_rdata_hold", dfp_rdata, last_rd);
    dfp_write = 1'b0;
    bmem_ready = 1'b0;
    mem[exp_a] = ln;
    @(negedge clk);
    check("wr_resp_pulse", dfp_resp, 0);
  endtask

  // Idle cycles with spurious returning beats that must be ignored.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = $urandom & ~32'h1F;
      bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      check("idle_no_read", bmem_read, 0);
      check("idle_no_write", bmem_write, 0);
      check("idle_no_resp", dfp_resp, 0);
      check("idle_rdata_hold", dfp_rdata, last_rd);
    end
    bmem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"}, bmem_read, 0);
    check({tag, "_write"}, bmem_write, 0);
    check({tag, "_addr"}, bmem_addr, 0);
    check({tag, "_wdata"}, bmem_wdata, 0);
    check({tag, "_resp"}, dfp_resp, 0);
    check({tag, "_rdata"}, dfp_rdata, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t ln;
    logic [31:0] a;

    tbl[0] = '{1'b0, 32'h0000_1040,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 32'h0000_1040};
    tbl[1] = '{1'b1, 32'h0000_2000,
               {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, 0, 0, 32'h0000_2000};
    tbl[2] = '{1'b0, 32'h0000_105F,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 3, 0, 32'h0000_1040};
    tbl[3] = '{1'b1, 32'h0000_2020,
               {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000}, 3, 0, 32'h0000_2020};
    tbl[4] = '{1'b0, 32'h0000_2000,
               {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, 0, 2, 32'h0000_2000};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].addr, tbl[i].exp_addr, tbl[i].line, tbl[i].stall);
      end else begin
        mem[tbl[i].exp_addr] = tbl[i].line;
        do_read(tbl[i].addr, tbl[i].exp_addr, tbl[i].stall, tbl[i].gap);
      end
    end

    // Stray beats while idle, then a gapped read that must be unaffected.
    idle_noise(3);
    do_read(32'h0000_4000, 32'h0000_4000, 1, 2);

    // Reset in the middle of a write burst.
    ln = rand_line();
    dfp_addr = 32'h0000_2000;
    dfp_wdata = ln;
    dfp_write = 1'b1;
    bmem_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_beat2", bmem_wdata, ln[128 +: 64]);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    dfp_write = 1'b0;
    bmem_ready = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_abort");
    do_read(32'h0000_3000, 32'h0000_3000, 0, 1);

    // Randomized traffic over a small line pool so reads revisit written lines.
    for (int t = 0; t < 40; t++) begin
      a = 32'h0000_8000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1)
        do_write(a, a & ~32'h1F, rand_line(), $urandom_range(0, 3));
      else
        do_read(a, a & ~32'h1F, $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle_noise($urandom_range(1, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
